writeback_arbiter: RTL and testbench

- Producer-side counterpart of the register file's single write port (write address, write data; address 0 = no write).
- Merges two result sources onto that one port:
  - Source A: in-order pipeline writeback. Highest priority, never stalled.
  - Source B: long-latency unit (mul/div, load miss). Uses a valid/ready handshake and is buffered in a small FIFO.
- Exports a pending-write mask to the hazard unit so decode can stall on registers with queued writes.

---
 rtl/writeback_arbiter_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 88 ++++++++
 rtl/writeback_arbiter.sv | 94 +++++++++
 tb/tb_writeback_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: register addresses and
// the queued source-B result entry.
package writeback_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // The data field is sized for the widest result the arbiter may carry.
  typedef struct packed {
    reg_addr_t         addr;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;

  function automatic logic [31:0] reg_onehot(input reg_addr_t a);
    return 32'd1 << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of source-B results with per-slot live bits, parallel
// cancel-by-address and a head-peek output.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  wb_entry_t        i_push_entry,
  input  logic             i_pop,
  input  reg_addr_t        i_cancel_addr,
  output wb_entry_t        o_head,
  output logic             o_head_valid,
  output logic [AW:0]      o_count,
  output logic [DEPTH-1:0] o_slot_live,
  output reg_addr_t        o_slot_addr [DEPTH]
);

  reg_addr_t         r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_occ;
  logic [DEPTH-1:0]  r_live;
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [AW:0]       r_count;

  logic w_push;
  logic w_pop;

  // DEPTH is a power of two, so the MSB of the count alone flags "full".
  assign w_push = i_push && !r_count[AW];
  assign w_pop  = i_pop && r_occ[r_head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ   <= '0;
      r_live  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_cancel_addr != REG_ZERO && r_addr[i] == i_cancel_addr) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_occ[r_head] <= 1'b0;
        r_head        <= r_head + AW'(1);
      end
      // A push never targets an occupied slot, so it safely overrides a cancel.
      if (w_push) begin
        r_occ[r_tail]  <= 1'b1;
        r_live[r_tail] <= i_push_entry.live;
        r_tail         <= r_tail + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the payload array carries no reset; an unoccupied slot is masked by
  // r_occ, so clearing storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= i_push_entry.addr;
      r_data[r_tail] <= i_push_entry.data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_slot_addr[i] = r_addr[i];
    end
  end

  assign o_head       = '{addr: r_addr[r_head], data: r_data[r_head], live: r_live[r_head]};
  assign o_head_valid = r_occ[r_head];
  assign o_count      = r_count;
  assign o_slot_live  = r_occ & r_live;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the in-order writeback (A) and the buffered long-latency unit (B) onto
// the single register-file write port, and exports the pending-write mask.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             a_addr,
  input  logic [W-1:0]           a_data,
  input  logic                   b_valid,
  input  logic [4:0]             b_addr,
  input  logic [W-1:0]           b_data,
  output logic                   b_ready,
  output logic [4:0]             wr_addr,
  output logic [W-1:0]           wr_data,
  output logic [31:0]            pending,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t        w_head;
  wb_entry_t        w_push_entry;
  logic             w_head_valid;
  logic             w_head_live;
  logic             w_a_active;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count;
  logic [DEPTH-1:0] w_slot_live;
  reg_addr_t        w_slot_addr [DEPTH];
  logic [31:0]      w_pending;

  assign w_a_active  = (a_addr != REG_ZERO);
  assign w_head_live = w_head_valid && w_head.live;

  // A dead head leaves in any cycle; a live one only after it has written.
  assign w_pop = w_head_valid && (!w_head.live || !w_a_active);

  assign b_ready = !reset && !w_count[AW];

  // An accepted B result aimed at r0, or at the register A writes this cycle,
  // is dropped: A is younger and would overwrite it anyway.
  assign w_push = b_valid && b_ready && (b_addr != REG_ZERO)
                  && !(w_a_active && b_addr == a_addr);

  assign w_push_entry = '{addr: b_addr, data: DATA_W'(b_data), live: 1'b1};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_push),
    .i_push_entry  (w_push_entry),
    .i_pop         (w_pop),
    .i_cancel_addr (a_addr),
    .o_head        (w_head),
    .o_head_valid  (w_head_valid),
    .o_count       (w_count),
    .o_slot_live   (w_slot_live),
    .o_slot_addr   (w_slot_addr)
  );

  // NOTE: every output of this block gets a default first so no path through
  // the if-chain can infer a latch.
  always_comb begin
    wr_addr = REG_ZERO;
    wr_data = '0;
    if (!reset) begin
      if (w_a_active) begin
        wr_addr = a_addr;
        wr_data = a_data;
      end else if (w_head_live) begin
        wr_addr = w_head.addr;
        wr_data = W'(w_head.data);
      end
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_slot_live[i]) begin
        w_pending = w_pending | reg_onehot(w_slot_addr[i]);
      end
    end
  end

  assign pending = {w_pending[31:1], 1'b0};
  assign count   = w_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a queue-based reference of the
// source-B buffer checked every cycle, plus directed checks for each scenario.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic         clk;
  logic         reset;
  logic [4:0]   a_addr;
  logic [W-1:0] a_data;
  logic         b_valid;
  logic [4:0]   b_addr;
  logic [W-1:0] b_data;
  logic         b_ready;
  logic [4:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [31:0]  pending;
  logic [2:0]   count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]   addr;
    logic [W-1:0] data;
    logic         live;
  } m_entry_t;

  m_entry_t mq[$];

  writeback_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .b_ready (b_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .pending (pending),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference buffer: observed at the negative edge, then advanced to match
  // what the coming rising edge should do.
  logic [31:0]  m_pend;
  logic         m_ready;
  logic [4:0]   m_wa;
  logic [W-1:0] m_wd;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      m_ready = (mq.size() < DEPTH);
      m_pend  = '0;
      foreach (mq[i]) if (mq[i].live) m_pend[mq[i].addr] = 1'b1;
      if (a_addr != 5'd0) begin
        m_wa = a_addr;
        m_wd = a_data;
      end else if (mq.size() > 0 && mq[0].live) begin
        m_wa = mq[0].addr;
        m_wd = mq[0].data;
      end else begin
        m_wa = 5'd0;
        m_wd = '0;
      end
      check("sb_count", 32'(count), 32'(mq.size()));
      check("sb_pending", pending, m_pend);
      check("sb_b_ready", 32'(b_ready), 32'(m_ready));
      check("sb_wr_addr", 32'(wr_addr), 32'(m_wa));
      check("sb_wr_data", wr_data, m_wd);
      if (mq.size() > 0 && (!mq[0].live || a_addr == 5'd0)) void'(mq.pop_front());
      if (a_addr != 5'd0) foreach (mq[i]) if (mq[i].addr == a_addr) mq[i].live = 1'b0;
      if (b_valid && m_ready && b_addr != 5'd0 && !(a_addr != 5'd0 && b_addr == a_addr))
        mq.push_back('{b_addr, b_data, 1'b1});
    end
  end

  // One clock cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input logic [4:0] aa, input logic [W-1:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [W-1:0] bd);
    @(posedge clk);
    #1;
    a_addr  = aa;
    a_data  = ad;
    b_valid = bv;
    b_addr  = ba;
    b_data  = bd;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    a_addr  = '0;
    a_data  = '0;
    b_valid = 1'b0;
    b_addr  = '0;
    b_data  = '0;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    #20 reset = 1'b0;

    // Single B beat with A idle.
    cyc(5'd0, '0, 1'b1, 5'd5, 32'h11);
    check("t1_b_ready", 32'(b_ready), 32'd1);
    idle();
    check("t1_wr_addr", 32'(wr_addr), 32'd5);
    check("t1_wr_data", wr_data, 32'h11);
    check("t1_pending", pending, 32'h20);
    idle();
    check("t1_pending_after", pending, 32'h0);
    check("t1_count_after", 32'(count), 32'd0);

    // A owns the port while two B results queue, then they drain in order.
    cyc(5'd7, 32'hC, 1'b1, 5'd3, 32'hA);
    check("t2_wr_addr_a0", 32'(wr_addr), 32'd7);
    cyc(5'd7, 32'hC, 1'b1, 5'd4, 32'hB);
    check("t2_wr_addr_a1", 32'(wr_addr), 32'd7);
    check("t2_wr_data_a1", wr_data, 32'hC);
    idle();
    check("t2_pending", pending, 32'h18);
    check("t2_wr_r3", 32'(wr_addr), 32'd3);
    check("t2_data_r3", wr_data, 32'hA);
    idle();
    check("t2_wr_r4", 32'(wr_addr), 32'd4);
    check("t2_data_r4", wr_data, 32'hB);
    idle();
    check("t2_count", 32'(count), 32'd0);

    // Younger A write cancels a queued B result for the same register.
    cyc(5'd0, '0, 1'b1, 5'd9, 32'h1);
    cyc(5'd9, 32'h2, 1'b0, 5'd0, '0);
    check("t3_pending_before", pending, 32'h200);
    check("t3_wr_data", wr_data, 32'h2);
    idle();
    check("t3_pending_after", pending, 32'h0);
    check("t3_dead_no_write", 32'(wr_addr), 32'd0);
    check("t3_dead_count", 32'(count), 32'd1);
    idle();
    check("t3_count", 32'(count), 32'd0);

    // Same-cycle collision: B accepted but dropped.
    cyc(5'd6, 32'h7, 1'b1, 5'd6, 32'h5);
    check("t4_b_ready", 32'(b_ready), 32'd1);
    check("t4_wr_addr", 32'(wr_addr), 32'd6);
    check("t4_wr_data", wr_data, 32'h7);
    idle();
    check("t4_count", 32'(count), 32'd0);
    check("t4_pending", pending, 32'h0);

    // Fill under a busy A, refuse while full even as a dead head pops, then drain.
    cyc(5'd20, 32'h20, 1'b1, 5'd10, 32'h10);
    cyc(5'd20, 32'h20, 1'b1, 5'd11, 32'h11);
    cyc(5'd20, 32'h20, 1'b1, 5'd12, 32'h12);
    cyc(5'd20, 32'h20, 1'b1, 5'd13, 32'h13);
    cyc(5'd10, 32'h30, 1'b1, 5'd14, 32'h14);
    check("t5_full_count", 32'(count), 32'd4);
    check("t5_full_ready", 32'(b_ready), 32'd0);
    cyc(5'd21, 32'h31, 1'b1, 5'd14, 32'h14);
    check("t5_deadpop_ready", 32'(b_ready), 32'd0);
    check("t5_deadpop_count", 32'(count), 32'd4);
    cyc(5'd21, 32'h31, 1'b1, 5'd14, 32'h14);
    check("t5_reopen_ready", 32'(b_ready), 32'd1);
    check("t5_reopen_count", 32'(count), 32'd3);
    cyc(5'd21, 32'h31, 1'b0, 5'd0, '0);
    check("t5_refull_ready", 32'(b_ready), 32'd0);
    idle();
    check("t5_drain_r11", 32'(wr_addr), 32'd11);
    check("t5_drain_ready", 32'(b_ready), 32'd0);
    idle();
    check("t5_drain_r12", 32'(wr_addr), 32'd12);
    check("t5_ready_back", 32'(b_ready), 32'd1);
    idle();
    idle();
    check("t5_drain_r14", 32'(wr_addr), 32'd14);
    check("t5_data_r14", wr_data, 32'h14);
    idle();
    check("t5_count", 32'(count), 32'd0);

    // Asynchronous reset with three entries queued.
    cyc(5'd20, 32'h20, 1'b1, 5'd1, 32'hAA);
    cyc(5'd20, 32'h20, 1'b1, 5'd2, 32'hBB);
    cyc(5'd20, 32'h20, 1'b1, 5'd3, 32'hCC);
    cyc(5'd20, 32'h20, 1'b0, 5'd0, '0);
    check("t6_count_before", 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_pending", pending, 32'h0);
    check("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("t6_rst_b_ready", 32'(b_ready), 32'd0);
    a_addr = '0;
    a_data = '0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    idle();
    check("t6_b_ready", 32'(b_ready), 32'd1);
    check("t6_no_write", 32'(wr_addr), 32'd0);
    idle();
    idle();
    check("sb_empty", 32'(mq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
